// File: rtl/core_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_seq_pkg
//  Description : Shared types and constants for the core_seq sequencer.
//                Provides the FSM state encoding and the default reset PC.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_seq_pkg;

    // Default program counter after reset.
    localparam logic [31:0] c_reset_pc_default = 32'h8000_0000;

    // Sequencer states, explicitly encoded in 3 bits.
    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_WAIT_I   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM      = 3'd3,
        S_MEM_WAIT = 3'd4,
        S_HALT     = 3'd5,
        S_FAULT    = 3'd6
    } core_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/core_seq_timer.sv
`default_nettype none
// ============================================================================
//  Module      : seq_timer
//  Description : Per-phase bus wait timer. Cleared when the sequencer enters
//                a wait phase, counts each cycle spent waiting, and flags the
//                TIMEOUT-th wait cycle so the FSM can fault if no handshake
//                arrives in that same cycle.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                clear         - restart the count at zero
//                enable        - count this cycle (sequencer is waiting)
//                expired       - current cycle is the last allowed wait cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);
    // The count is zero in the first wait cycle, so the TIMEOUT-th wait cycle
    // is the one where the count equals TIMEOUT-1.
    localparam logic [TW-1:0] c_last = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_count;

    assign expired = (r_count == c_last);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + TW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_seq.sv
`default_nettype none
// ============================================================================
//  Module      : core_seq
//  Description : Multi-cycle instruction sequencer. Fetches an instruction
//                over a valid/ready bus, lets decode/execute evaluate while
//                it is held, performs an optional data access, then commits
//                (rf_wen pulse, PC update, instret increment).
//  Ports       : clk, rst                         - clock, sync reset
//                imem_valid/ready/rvalid, ir_en   - instruction bus
//                dec_*                            - decoder flags
//                pc_branch, target_pc             - execution unit redirect
//                dmem_valid/we/ready/rvalid       - data bus
//                pc, rf_wen, instret              - architectural outputs
//                halt, fault                      - terminal status
//  Revision    : 1.0 - initial release
// ============================================================================
module core_seq
    import core_seq_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_reset_pc_default),
    parameter int              TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_valid,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    output logic            ir_en,
    input  logic            dec_mem_read,
    input  logic            dec_mem_write,
    input  logic            dec_rd_write,
    input  logic            dec_illegal,
    input  logic            dec_ebreak,
    input  logic            pc_branch,
    input  logic [XLEN-1:0] target_pc,
    output logic            dmem_valid,
    output logic            dmem_we,
    input  logic            dmem_ready,
    input  logic            dmem_rvalid,
    output logic [XLEN-1:0] pc,
    output logic            rf_wen,
    output logic [63:0]     instret,
    output logic            halt,
    output logic            fault
);

    core_seq_state_t r_state;
    core_seq_state_t w_state_next;

    logic [XLEN-1:0] r_pc;
    logic [63:0]     r_instret;

    logic w_commit_req;   // instruction reached a commit point this cycle
    logic w_commit;       // commit point and target is aligned
    logic w_misaligned;
    logic w_waiting;      // sitting in a bus wait phase
    logic w_tmr_clear;
    logic w_tmr_expired;

    seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_tmr_clear),
        .enable  (w_waiting),
        .expired (w_tmr_expired)
    );

    assign w_misaligned = pc_branch && (target_pc[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_commit_req = 1'b0;
        w_commit     = 1'b0;
        w_waiting    = 1'b0;

        case (r_state)
            S_FETCH: begin
                // Late responses from an aborted instruction may still show
                // up here; only the address handshake matters.
                if (imem_ready) begin
                    w_state_next = S_WAIT_I;
                end
            end
            S_WAIT_I: begin
                w_waiting = 1'b1;
                if (imem_rvalid) begin
                    w_state_next = S_EXEC;
                end else if (w_tmr_expired) begin
                    w_state_next = S_FAULT;
                end
            end
            S_EXEC: begin
                if (dec_illegal) begin
                    w_state_next = S_FAULT;
                end else if (dec_ebreak) begin
                    w_state_next = S_HALT;
                end else if (dec_mem_read || dec_mem_write) begin
                    w_state_next = S_MEM;
                end else begin
                    w_commit_req = 1'b1;
                end
            end
            S_MEM: begin
                w_waiting = 1'b1;
                if (dmem_ready) begin
                    if (dec_mem_write) begin
                        w_commit_req = 1'b1;
                    end else begin
                        w_state_next = S_MEM_WAIT;
                    end
                end else if (w_tmr_expired) begin
                    w_state_next = S_FAULT;
                end
            end
            S_MEM_WAIT: begin
                w_waiting = 1'b1;
                if (dmem_rvalid) begin
                    w_commit_req = 1'b1;
                end else if (w_tmr_expired) begin
                    w_state_next = S_FAULT;
                end
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            S_FAULT: begin
                w_state_next = S_FAULT;
            end
            default: begin
                w_state_next = S_FAULT;
            end
        endcase

        // A misaligned redirect turns the commit into a fault with no
        // architectural side effects.
        if (w_commit_req) begin
            if (w_misaligned) begin
                w_state_next = S_FAULT;
            end else begin
                w_commit     = 1'b1;
                w_state_next = S_FETCH;
            end
        end
    end

    // Every state change restarts the timer, so each wait phase starts at 0.
    assign w_tmr_clear = (w_state_next != r_state);

    // ------------------------------------------------------------------
    // PC and retired-instruction counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_instret <= 64'd0;
        end else if (w_commit) begin
            r_pc      <= pc_branch ? target_pc : (r_pc + XLEN'(4));
            r_instret <= r_instret + 64'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output decode; everything except pc is forced low during reset.
    // ------------------------------------------------------------------
    assign pc         = r_pc;
    assign instret    = r_instret;
    assign imem_valid = !rst && (r_state == S_FETCH);
    assign ir_en      = !rst && (r_state == S_WAIT_I) && imem_rvalid;
    assign dmem_valid = !rst && (r_state == S_MEM);
    assign dmem_we    = dmem_valid && dec_mem_write;
    assign rf_wen     = !rst && w_commit && dec_rd_write;
    assign halt       = !rst && (r_state == S_HALT);
    assign fault      = !rst && (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_core_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_seq
//  Description : Directed self-checking bench for core_seq. Expected commit
//                results are queued when an instruction is presented and
//                compared when the sequencer reaches its commit point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_seq;

    localparam logic [31:0] c_rst_pc = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_valid, imem_ready, imem_rvalid, ir_en;
    logic        dec_mem_read, dec_mem_write, dec_rd_write, dec_illegal, dec_ebreak;
    logic        pc_branch;
    logic [31:0] target_pc;
    logic        dmem_valid, dmem_we, dmem_ready, dmem_rvalid;
    logic [31:0] pc;
    logic        rf_wen;
    logic [63:0] instret;
    logic        halt, fault;

    core_seq #(
        .XLEN     (32),
        .RESET_PC (c_rst_pc),
        .TIMEOUT  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_valid    (imem_valid),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .ir_en         (ir_en),
        .dec_mem_read  (dec_mem_read),
        .dec_mem_write (dec_mem_write),
        .dec_rd_write  (dec_rd_write),
        .dec_illegal   (dec_illegal),
        .dec_ebreak    (dec_ebreak),
        .pc_branch     (pc_branch),
        .target_pc     (target_pc),
        .dmem_valid    (dmem_valid),
        .dmem_we       (dmem_we),
        .dmem_ready    (dmem_ready),
        .dmem_rvalid   (dmem_rvalid),
        .pc            (pc),
        .rf_wen        (rf_wen),
        .instret       (instret),
        .halt          (halt),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        rfw;
        logic [31:0] pc;
        logic [63:0] ret;
        logic        flt;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    logic [63:0] m_ret;
    int          commit_cyc;
    int          c1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        imem_ready    = 1'b0;
        imem_rvalid   = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_rd_write  = 1'b0;
        dec_illegal   = 1'b0;
        dec_ebreak    = 1'b0;
        pc_branch     = 1'b0;
        target_pc     = 32'h0;
        dmem_ready    = 1'b0;
        dmem_rvalid   = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_outputs", {59'd0, imem_valid, ir_en, dmem_valid, rf_wen, halt | fault}, 64'd0);
        chk("rst_pc", pc, c_rst_pc);
        chk("rst_instret", instret, 64'd0);
        rst   = 1'b0;
        m_pc  = c_rst_pc;
        m_ret = 64'd0;
    endtask

    // Fetch with rdy_wait stalled FETCH cycles and rv_wait empty WAIT_I cycles.
    task automatic do_fetch(input int rdy_wait, input int rv_wait);
        for (int i = 0; i < rdy_wait; i++) begin
            #1 chk("imem_valid_hold", imem_valid, 1);
            tick();
        end
        imem_ready = 1'b1;
        #1 chk("imem_valid", imem_valid, 1);
        tick();
        imem_ready = 1'b0;
        for (int i = 0; i < rv_wait; i++) begin
            #1 chk("ir_en_idle", ir_en, 0);
            tick();
        end
        imem_rvalid = 1'b1;
        #1 chk("ir_en", ir_en, 1);
        tick();
        imem_rvalid = 1'b0;
    endtask

    // Present a decoded instruction in EXEC and follow it to its commit point.
    task automatic do_exec(input bit rd, input bit ld, input bit st, input bit br,
                           input logic [31:0] tgt, input int dwait, input int rwait);
        exp_t e;
        bit   mis;
        mis   = br && (tgt[1:0] != 2'b00);
        e.flt = mis;
        e.rfw = !mis && rd;
        e.pc  = mis ? m_pc : (br ? tgt : m_pc + 32'd4);
        e.ret = mis ? m_ret : m_ret + 64'd1;
        sbq.push_back(e);

        dec_rd_write  = rd;
        dec_mem_read  = ld;
        dec_mem_write = st;
        pc_branch     = br;
        target_pc     = tgt;
        if (ld || st) begin
            #1 chk("exec_no_wen", rf_wen, 0);
            tick();
            for (int i = 0; i < dwait; i++) begin
                #1 chk("dmem_hold", {62'd0, dmem_valid, dmem_we}, {62'd0, 1'b1, st});
                tick();
            end
            dmem_ready = 1'b1;
            #1 chk("dmem_req", {62'd0, dmem_valid, dmem_we}, {62'd0, 1'b1, st});
            if (!st) begin
                chk("ld_ready_no_wen", rf_wen, 0);
                tick();
                dmem_ready = 1'b0;
                for (int i = 0; i < rwait; i++) begin
                    #1 chk("ld_wait_no_wen", rf_wen, 0);
                    tick();
                end
                dmem_rvalid = 1'b1;
                #1;
            end
        end else begin
            #1;
        end
        e = sbq.pop_front();
        chk("commit_wen", rf_wen, e.rfw);
        commit_cyc = cyc;
        tick();
        clear_in();
        chk("pc", pc, e.pc);
        chk("instret", instret, e.ret);
        chk("fault", fault, e.flt);
        m_pc  = e.pc;
        m_ret = e.ret;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        #1 chk("imem_valid_first", imem_valid, 1);

        // Two back-to-back ADDIs on zero-wait buses.
        do_fetch(0, 0);
        do_exec(1, 0, 0, 0, 32'h0, 0, 0);
        c1 = commit_cyc;
        do_fetch(0, 0);
        do_exec(1, 0, 0, 0, 32'h0, 0, 0);
        chk("alu_cadence", 64'(commit_cyc - c1), 64'd3);
        chk("pc_after_two", pc, 32'h8000_0008);

        // Aligned JAL, then misaligned JAL that must fault without commit.
        do_fetch(1, 1);
        do_exec(1, 0, 0, 1, 32'h8000_0100, 0, 0);
        do_fetch(0, 0);
        do_exec(1, 0, 0, 1, 32'h8000_0102, 0, 0);
        repeat (3) begin
            imem_ready = 1'b1;
            #1 chk("fault_quiet", {61'd0, imem_valid, dmem_valid, rf_wen}, 64'd0);
            chk("fault_held", fault, 1);
            tick();
        end
        chk("fault_pc_kept", pc, 32'h8000_0100);

        // Load with stalls, then a store.
        do_reset();
        do_fetch(0, 0);
        do_exec(1, 1, 0, 0, 32'h0, 3, 2);
        do_fetch(0, 0);
        do_exec(0, 0, 1, 0, 32'h0, 1, 0);

        // Instruction read data withheld: fault four cycles after WAIT_I entry.
        do_reset();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("tmo_no_fault_yet", fault, 0);
            tick();
        end
        #1 chk("tmo_fault", fault, 1);

        // Read data on the last allowed cycle still proceeds normally.
        do_reset();
        do_fetch(0, 3);
        chk("tmo_edge_no_fault", fault, 0);
        do_exec(1, 0, 0, 0, 32'h0, 0, 0);

        // EBREAK halts with no commit and a silent bus.
        do_fetch(0, 0);
        dec_ebreak   = 1'b1;
        dec_rd_write = 1'b1;
        #1 chk("ebreak_no_wen", rf_wen, 0);
        tick();
        clear_in();
        for (int i = 0; i < 20; i++) begin
            imem_ready  = 1'($urandom_range(0, 1));
            dmem_ready  = 1'($urandom_range(0, 1));
            dmem_rvalid = 1'($urandom_range(0, 1));
            #1 chk("halt_held", halt, 1);
            chk("halt_quiet", {61'd0, imem_valid, dmem_valid, rf_wen}, 64'd0);
            tick();
        end
        clear_in();
        chk("halt_instret", instret, m_ret);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 chk("restart_pc", pc, c_rst_pc);
        chk("restart_halt", halt, 0);
        chk("restart_fetch", imem_valid, 1);
        m_pc  = c_rst_pc;
        m_ret = 64'd0;

        // Reset during MEM_WAIT; the stale load response lands in FETCH.
        do_fetch(0, 0);
        dec_mem_read = 1'b1;
        dec_rd_write = 1'b1;
        tick();
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        rst = 1'b1;
        #1 chk("abort_no_wen", rf_wen, 0);
        tick();
        rst         = 1'b0;
        dmem_rvalid = 1'b1;
        #1 chk("stale_no_wen", rf_wen, 0);
        chk("stale_fetch", imem_valid, 1);
        tick();
        clear_in();
        chk("stale_instret", instret, 64'd0);
        chk("stale_pc", pc, c_rst_pc);
        do_fetch(0, 0);
        do_exec(1, 0, 0, 0, 32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_seq.md
# core_seq

Multi-cycle sequencer for the core's execution datapath. Fetches one instruction at a time over a valid/ready instruction bus, holds it while the decoder and execution unit evaluate combinationally, and issues an optional data-bus access. It commits the result by pulsing the register-file write enable and updating the PC. It sits between the bus interfaces and the decode/execute units, and replaces single-cycle sequencing when memories have variable latency.

## Interface
- XLEN, 32, datapath/PC width
- RESET_PC, 32'h8000_0000, PC value after reset
- TIMEOUT, 255, maximum wait cycles per bus phase before a fault is raised

- clk  input  1  core clock
- rst  input  1  reset, synchronous, active-high
- imem_valid  output  1  fetch request; imem_addr = pc
- imem_ready  input  1  fetch address accepted
- imem_rvalid  input  1  instruction data valid
- ir_en  output  1  load instruction register
- dec_mem_read  input  1  decoded instruction is a load
- dec_mem_write  input  1  decoded instruction is a store
- dec_rd_write  input  1  decoded instruction writes rd
- dec_illegal  input  1  decoded instruction is illegal
- dec_ebreak  input  1  decoded instruction is EBREAK
- pc_branch  input  1  execution unit: take target_pc
- target_pc  input  XLEN  execution unit branch/jump target
- dmem_valid  output  1  data request
- dmem_we  output  1  data request is a write
- dmem_ready  input  1  data request accepted
- dmem_rvalid  input  1  load data valid
- pc  output  XLEN  current PC (register)
- rf_wen  output  1  register-file write strobe (one cycle)
- instret  output  64  committed-instruction counter
- halt  output  1  EBREAK reached
- fault  output  1  illegal instruction, misaligned target, or bus timeout

## Operation
- States: FETCH, WAIT_I, EXEC, MEM, MEM_WAIT, HALT, FAULT.
- FETCH:
  - imem_valid=1.
  - imem_ready → WAIT_I.
  - imem_rvalid is ignored in FETCH.
- WAIT_I:
  - imem_rvalid → ir_en=1 → EXEC.
- EXEC (decode inputs valid this cycle), checked in priority order:
  - dec_illegal → FAULT.
  - dec_ebreak → HALT. No commit.
  - mem_read or mem_write → MEM.
  - Otherwise commit → FETCH.
- MEM:
  - dmem_valid=1; dmem_we=dec_mem_write.
  - On dmem_ready: a store commits → FETCH; a load → MEM_WAIT.
- MEM_WAIT:
  - dmem_rvalid → commit → FETCH.
- Commit actions:
  - rf_wen = dec_rd_write.
  - next PC = pc_branch ? target_pc : pc+4 (modulo 2^XLEN).
  - instret += 1 (wraps at 2^64).
- Misaligned target: pc_branch=1 with target_pc[1:0]≠0 at a commit point → FAULT instead of commit. No rf_wen, PC and instret unchanged.
- Timeout counter:
  - Width $clog2(TIMEOUT+1).
  - Cleared on entry to WAIT_I, MEM, MEM_WAIT; increments each cycle waiting there.
  - Reaching TIMEOUT with no handshake in that cycle → FAULT.
  - A handshake in the same cycle as TIMEOUT wins.
- HALT and FAULT are terminal until rst. halt/fault are held high; all bus requests and strobes are 0.
- dec_* inputs are sampled only in EXEC, MEM, and MEM_WAIT.

## Timing
- Reset: state=FETCH, pc=RESET_PC, instret=0, timer=0.
  - While rst is high, every output is 0 except pc=RESET_PC.
  - imem_valid=1 in the first cycle after rst falls.
- Latency with zero-wait buses (imem_ready in FETCH, rvalid next cycle):
  - ALU/branch: 3 cycles/instruction.
  - Store: 4 cycles.
  - Load: 5 cycles.
- imem_valid and dmem_valid are held until ready. Request attributes are stable while valid and not ready.
- rvalid is required no earlier than one cycle after the ready handshake.
- Reset mid-operation aborts the instruction without commit. Stale responses arriving in FETCH are ignored.
- pc and instret change only in the cycle after a commit.

## Structure
- core_seq_pkg: state enum typedef (core_seq_state_t) and the RESET_PC default constant.
- Sub-module seq_timer: the per-phase timeout counter with clear, enable, and expired outputs.
- core_seq contains the FSM, the PC and instret registers, and the output decode.

## Test plan
- Reset release, zero-wait buses, ADDI stream → imem_valid in cycle 1; rf_wen every 3 cycles; pc 8000_0000→8000_0004→8000_0008; instret=2 after two commits.
- JAL with pc_branch=1, target_pc=8000_0100 → commit, pc=8000_0100; target_pc=8000_0102 → fault=1, rf_wen never pulses, instret unchanged.
- Load with dmem_ready after 3 stalls and rvalid after 2 more → single rf_wen on the rvalid cycle; store completes at dmem_ready with rf_wen=0.
- TIMEOUT=4, imem_rvalid withheld → fault asserted exactly 4 cycles after WAIT_I entry; rvalid arriving on the 4th cycle → normal EXEC.
- dec_ebreak → halt=1, bus valids stay 0 for 20 cycles; rst pulse → pc=RESET_PC, halt=0, fetch restarts.
- rst asserted in MEM_WAIT, then dmem_rvalid arrives in FETCH → no rf_wen, instret=0, fetch of RESET_PC proceeds.
